// File: rtl/lift_call_scheduler.sv
// Hall-call latch and SCAN scheduler for a 4-floor lift: offers one call at a time to LiftFSM,
// retires it on lift_done, and re-offers it if the done-watchdog expires.
module lift_call_scheduler #(
  parameter int unsigned DONE_TIMEOUT = 255,
  parameter int unsigned TMO_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] call_btn,
  input  logic       lift_done,
  output logic [2:0] call_code,
  output logic       q_empty,
  output logic [5:0] call_lamp,
  output logic       sweep_dir,
  output logic [1:0] cur_floor,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, RETIRE, ABORT} state_t;

  localparam bit               WD_EN   = (DONE_TIMEOUT != 0);
  localparam logic [TMO_W-1:0] WD_LAST = TMO_W'(WD_EN ? DONE_TIMEOUT - 1 : 0);

  state_t           state_q, state_d;
  logic [5:0]       lamp_q, lamp_d;
  logic [2:0]       code_q, code_d;
  logic [2:0]       idx_q, idx_d;
  logic             dir_q, dir_d;
  logic [1:0]       cur_q, cur_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             q_empty_q, q_empty_d;
  logic             terr_q, terr_d;

  logic [2:0] cf;
  logic [3:0] sa, sb, sc, sd;
  logic [2:0] pick;
  logic       flip;

  function automatic logic [2:0] floor_of(input logic [2:0] idx);
    case (idx)
      3'd0:    floor_of = 3'd1;
      3'd1:    floor_of = 3'd2;
      3'd2:    floor_of = 3'd3;
      3'd3:    floor_of = 3'd2;
      3'd4:    floor_of = 3'd3;
      default: floor_of = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] code_of(input logic [2:0] idx);
    case (idx)
      3'd0:    code_of = 3'b001;
      3'd1:    code_of = 3'b010;
      3'd2:    code_of = 3'b011;
      3'd3:    code_of = 3'b110;
      3'd4:    code_of = 3'b111;
      default: code_of = 3'b100;
    endcase
  endfunction

  // Up-set {1U,2U,3U,4D} ascending; down-set {4D,3D,2D,1U} descending.
  function automatic logic [2:0] set_member(input logic down, input logic [1:0] k);
    case (k)
      2'd0:    set_member = down ? 3'd5 : 3'd0;
      2'd1:    set_member = down ? 3'd4 : 3'd1;
      2'd2:    set_member = down ? 3'd3 : 3'd2;
      default: set_member = down ? 3'd0 : 3'd5;
    endcase
  endfunction

  // Returns {found, idx}; first pending member in set order, optionally only ahead of cf.
  function automatic logic [3:0] scan_set(input logic [5:0] lamp, input logic down,
                                          input logic ahead, input logic [2:0] cf_in);
    logic [3:0] r;
    logic [2:0] m, f;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      m = set_member(down, 2'(k));
      f = floor_of(m);
      if (!r[3] && lamp[m] && (!ahead || (down ? (f <= cf_in) : (f >= cf_in))))
        r = {1'b1, m};
    end
    return r;
  endfunction

  always_comb begin
    cf = (cur_q == 2'b00) ? 3'd4 : {1'b0, cur_q};
    sa = scan_set(lamp_q,  dir_q, 1'b1, cf);
    sb = scan_set(lamp_q, ~dir_q, 1'b1, cf);
    sc = scan_set(lamp_q,  dir_q, 1'b0, cf);
    sd = scan_set(lamp_q, ~dir_q, 1'b0, cf);
    if (sa[3])      begin pick = sa[2:0]; flip = 1'b0; end
    else if (sb[3]) begin pick = sb[2:0]; flip = 1'b1; end
    else if (sc[3]) begin pick = sc[2:0]; flip = 1'b0; end
    else            begin pick = sd[2:0]; flip = 1'b1; end
  end

  always_comb begin
    state_d = state_q;
    lamp_d  = lamp_q | call_btn;
    code_d  = code_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE:   if (lamp_q != '0) state_d = SELECT;
      SELECT: begin
        if (lamp_q == '0) begin
          state_d = IDLE;
        end else begin
          idx_d   = pick;
          code_d  = code_of(pick);
          dir_d   = dir_q ^ flip;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (lift_done)                      state_d = RETIRE;
        else if (WD_EN && wd_q == WD_LAST)  state_d = ABORT;
        else if (WD_EN)                     wd_d    = wd_q + TMO_W'(1);
      end
      RETIRE: begin
        // Clear beats a same-cycle press of the served button.
        lamp_d[idx_q] = 1'b0;
        cur_d         = code_q[1:0];
        state_d       = (lamp_d != '0) ? SELECT : IDLE;
      end
      ABORT:   state_d = SELECT;
      default: state_d = IDLE;
    endcase
    q_empty_d = (state_d != ISSUE);
    terr_d    = (state_d == ABORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lamp_q    <= '0;
      code_q    <= 3'b001;
      idx_q     <= 3'd0;
      dir_q     <= 1'b0;
      cur_q     <= 2'b01;
      wd_q      <= '0;
      q_empty_q <= 1'b1;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lamp_q    <= lamp_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      dir_q     <= dir_d;
      cur_q     <= cur_d;
      wd_q      <= wd_d;
      q_empty_q <= q_empty_d;
      terr_q    <= terr_d;
    end
  end

  assign call_code   = code_q;
  assign q_empty     = q_empty_q;
  assign call_lamp   = lamp_q;
  assign sweep_dir   = dir_q;
  assign cur_floor   = cur_q;
  assign timeout_err = terr_q;

endmodule
